// File: rtl/dpwm_pkg.sv
// Shared types and constants for the DPWM duty-capture block.
// Optional glitch filter is enabled with the DPWM_CAP_GLITCH_FILTER_EN macro.
package dpwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } cap_state_t;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // All-ones value of a w-bit counter; valid for w up to 31.
  function automatic int unsigned cnt_limit(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/dpwm_duty_capture_if.sv
// Result bus of the duty-capture block: PWM input in, duty/period words and status out.
// The capture block takes the master side.
interface dpwm_duty_capture_if
  import dpwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             pwm_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;
  logic             level;

  modport master (
    input  pwm_in,
    output duty,
    output period,
    output valid,
    output timeout,
    output level
  );

  modport slave (
    output pwm_in,
    input  duty,
    input  period,
    input  valid,
    input  timeout,
    input  level
  );
endinterface

// File: rtl/dpwm_sync_edge.sv
// Synchronizer, optional 3-sample glitch filter (DPWM_CAP_GLITCH_FILTER_EN),
// delay flop and rising-edge detect for the asynchronous PWM input.
module dpwm_sync_edge
  import dpwm_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   lvl;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef DPWM_CAP_GLITCH_FILTER_EN
  logic hist_p1;
  logic hist_p2;
  logic filt_q;
  logic filt_d;

  // Level flips only once the current and two previous samples agree, so
  // the filtered level moves two cycles after the synchronized one.
  always_comb begin
    filt_d = filt_q;
    if (sync_lvl && hist_p1 && hist_p2) begin
      filt_d = 1'b1;
    end else if (!sync_lvl && !hist_p1 && !hist_p2) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_p1 <= 1'b0;
      hist_p2 <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist_p1 <= sync_lvl;
      hist_p2 <= hist_p1;
      filt_q  <= filt_d;
    end
  end

  assign lvl = filt_d;
`else
  assign lvl = sync_lvl;
`endif

  // ---- edge-detect stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= 1'b0;
    end else begin
      dly_q <= lvl;
    end
  end

  assign level = lvl;
  assign rise  = lvl & ~dly_q;

endmodule

// File: rtl/dpwm_duty_capture.sv
// DPWM duty-capture top: measures high time and period of pwm_in in clk cycles
// and reports them once per PWM period. Glitch filter: DPWM_CAP_GLITCH_FILTER_EN.
module dpwm_duty_capture
  import dpwm_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  dpwm_duty_capture_if.master  cap
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(cnt_limit(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             level;
  logic             rise;

  cap_state_t       state_q;
  cap_state_t       state_d;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_d;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] hi_d;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic             vld_p1;
  logic             vld_d;
  logic             tmo_q;
  logic             tmo_d;

  dpwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (cap.pwm_in),
    .level  (level),
    .rise   (rise)
  );

  // The rise-cycle sample is the first high cycle of the new period, so both
  // counters restart at 1; hi_q can never overtake per_q.
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    duty_d   = duty_q;
    period_d = period_q;
    vld_d    = 1'b0;
    tmo_d    = tmo_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          per_d   = CNT_ONE;
          hi_d    = CNT_ONE;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (rise) begin
          // Capture takes priority over a timeout landing on the same cycle.
          period_d = per_q;
          duty_d   = hi_q;
          vld_d    = 1'b1;
          tmo_d    = 1'b0;
          per_d    = CNT_ONE;
          hi_d     = CNT_ONE;
        end else if (per_q == CNT_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          per_d = per_q + CNT_ONE;
          hi_d  = hi_q + CNT_W'(level);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- measurement / output register stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      duty_q   <= '0;
      period_q <= '0;
      vld_p1   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      vld_p1   <= vld_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cap.duty    = duty_q;
  assign cap.period  = period_q;
  assign cap.valid   = vld_p1;
  assign cap.timeout = tmo_q;
  assign cap.level   = level;

endmodule

// File: tb/tb_dpwm_duty_capture.sv
// Directed bench for dpwm_duty_capture: periodic waveforms, mid-run duty change,
// timeout, 255-cycle boundary, reset, minimum period and glitch handling.
module tb_dpwm_duty_capture;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
`ifdef DPWM_CAP_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 2;
`else
  localparam int LAT = SYNC;
`endif

  logic clk;
  logic rst;

  dpwm_duty_capture_if #(.CNT_W(CNT_W)) cap ();

  dpwm_duty_capture #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cap (cap)
  );

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int nvalid    = 0;
  int nduty1    = 0;
  int last_rise = 0;
  int target    = 0;
  logic [CNT_W-1:0] vduty = '0;
  logic [CNT_W-1:0] vper  = '0;
  logic prev_pwm = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk cycle with pwm_in = v; valid pulses are recorded at the negedge.
  task automatic step(input logic v);
    if (v && !prev_pwm) last_rise = cyc;
    prev_pwm   = v;
    cap.pwm_in = v;
    @(posedge clk);
    @(negedge clk);
    if (cap.valid === 1'b1) begin
      nvalid++;
      vduty = cap.duty;
      vper  = cap.period;
      if (cap.duty == 1) nduty1++;
    end
    cyc++;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  // 3 high, 3 low, a 1-cycle glitch, 1 low: period 8
  task automatic glitch_wave(input int n);
    for (int p = 0; p < n; p++) begin
      step(1'b1); step(1'b1); step(1'b1);
      step(1'b0); step(1'b0); step(1'b0);
      step(1'b1); step(1'b0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cap.pwm_in = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_duty",    32'(cap.duty),    0);
    chk("rst_period",  32'(cap.period),  0);
    chk("rst_valid",   32'(cap.valid),   0);
    chk("rst_timeout", 32'(cap.timeout), 0);
    chk("rst_level",   32'(cap.level),   0);
    rst = 1'b1;

    // 3 high / 5 low
    nvalid = 0;
    wave(3, 5, 1);
    chk("first_rise_no_valid", nvalid, 0);
    wave(3, 5, 3);
    chk("p35_count",  nvalid, 3);
    chk("p35_duty",   32'(vduty), 3);
    chk("p35_period", 32'(vper), 8);

    // switch to 6 high / 2 low
    nvalid = 0;
    wave(6, 2, 1);
    chk("sw1_count",  nvalid, 1);
    chk("sw1_duty",   32'(vduty), 3);
    chk("sw1_period", 32'(vper), 8);
    nvalid = 0;
    wave(6, 2, 1);
    chk("sw2_count",  nvalid, 1);
    chk("sw2_duty",   32'(vduty), 6);
    chk("sw2_period", 32'(vper), 8);
    nvalid = 0;
    wave(6, 2, 2);
    chk("sw3_count",  nvalid, 2);
    chk("sw3_duty",   32'(vduty), 6);

    // hold low: timeout 255 cycles after the counters restarted
    nvalid = 0;
    target = last_rise + LAT + 254;
    while (cyc < target) step(1'b0);
    step(1'b0);
    chk("tmo_before", 32'(cap.timeout), 0);
    step(1'b0);
    chk("tmo_set",    32'(cap.timeout), 1);
    chk("tmo_level",  32'(cap.level),   0);
    chk("tmo_duty",   32'(cap.duty),    6);
    chk("tmo_period", 32'(cap.period),  8);
    chk("tmo_nvalid", nvalid, 0);

    // recovery: first rise only restarts, second rise reports
    wave(3, 5, 1);
    chk("rec1_timeout", 32'(cap.timeout), 1);
    chk("rec1_nvalid",  nvalid, 0);
    wave(3, 5, 1);
    chk("rec2_timeout", 32'(cap.timeout), 0);
    chk("rec2_nvalid",  nvalid, 1);
    chk("rec2_duty",    32'(vduty), 3);
    chk("rec2_period",  32'(vper), 8);

    // 255-cycle periods: rise coincides with the all-ones count
    nvalid = 0;
    wave(3, 252, 2);
    chk("bnd1_nvalid",  nvalid, 2);
    chk("bnd1_duty",    32'(vduty), 3);
    chk("bnd1_period",  32'(vper), 255);
    chk("bnd1_timeout", 32'(cap.timeout), 0);
    nvalid = 0;
    wave(3, 5, 1);
    chk("bnd2_nvalid",  nvalid, 1);
    chk("bnd2_period",  32'(vper), 255);
    chk("bnd2_timeout", 32'(cap.timeout), 0);

    // reset mid-period
    step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_duty",    32'(cap.duty),    0);
    chk("mrst_period",  32'(cap.period),  0);
    chk("mrst_valid",   32'(cap.valid),   0);
    chk("mrst_timeout", 32'(cap.timeout), 0);
    chk("mrst_level",   32'(cap.level),   0);
    @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    wave(3, 5, 1);
    chk("post_rst1_nvalid", nvalid, 0);
    chk("post_rst1_duty",   32'(cap.duty), 0);
    wave(3, 5, 1);
    chk("post_rst2_nvalid", nvalid, 1);
    chk("post_rst2_duty",   32'(vduty), 3);
    chk("post_rst2_period", 32'(vper), 8);

    // square wave 1 high / 1 low
    wave(1, 1, 3);
    nvalid = 0;
    wave(1, 1, 8);
`ifdef DPWM_CAP_GLITCH_FILTER_EN
    chk("sq_nvalid", nvalid, 0);
    chk("sq_duty",   32'(cap.duty), 3);
`else
    chk("sq_nvalid", nvalid, 8);
    chk("sq_duty",   32'(vduty), 1);
    chk("sq_period", 32'(vper), 2);
`endif

    // 1-cycle glitch in the low phase
    glitch_wave(2);
    nvalid = 0;
    nduty1 = 0;
    glitch_wave(2);
`ifdef DPWM_CAP_GLITCH_FILTER_EN
    chk("gl_nvalid", nvalid, 2);
    chk("gl_duty1",  nduty1, 0);
    chk("gl_duty",   32'(vduty), 3);
    chk("gl_period", 32'(vper), 8);
`else
    chk("gl_nvalid", nvalid, 4);
    chk("gl_duty1",  nduty1, 2);
    chk("gl_duty",   32'(vduty), 1);
    chk("gl_period", 32'(vper), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpwm_duty_capture.md
# dpwm_duty_capture

Duty-cycle capture block: the measuring end of the DPWM path. It samples an external PWM waveform, counts high-time and period in `clk` cycles, and reports both as binary words once per PWM period. It sits opposite the DPWM counter/comparator chain, either looping back the generated PWM for closed-loop checking or decoding an externally supplied PWM into a duty word.

## Interface
Parameters:
- `CNT_W`, 8, width of the duty and period words and of the internal counters.
- `SYNC_STAGES`, 2, number of synchronizer flops on `pwm_in` (minimum 2).

Ports:
- `clk`  in  1  single clock; everything is rising-edge triggered.
- `rst`  in  1  reset, asynchronous, active-low.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  CNT_W  high cycles in the last complete period; reset 0.
- `period`  out  CNT_W  total cycles in the last complete period; reset 0.
- `valid`  out  1  one-cycle pulse when `duty`/`period` update; reset 0.
- `timeout`  out  1  sticky; no rising edge within 2^CNT_W−1 cycles; reset 0.
- `level`  out  1  synchronized (and filtered) input level; reset 0.

## Operation
- Front end: `SYNC_STAGES` flops, then a delay flop. `rise` = s & ~d.
- Two states: IDLE (waiting for first rise) and MEASURE.
- IDLE, on `rise`:
  - load `per_cnt`=1, `hi_cnt`=1;
  - go to MEASURE;
  - no `valid`, because the period is incomplete.
- MEASURE, every cycle without `rise`:
  - `per_cnt`+1;
  - `hi_cnt`+1 when s=1.
- MEASURE on `rise`:
  - `period`←`per_cnt`, `duty`←`hi_cnt`;
  - `valid`=1 for that one cycle;
  - `timeout`←0;
  - reload both counters to 1.
- Rise-cycle sample counts as the first high cycle of the new period. Hence 1 ≤ `duty` ≤ `period`−1, and minimum `period` = 2.
- Timeout: in MEASURE with `per_cnt` = all-ones and no `rise`:
  - `timeout`←1 and go to IDLE;
  - `duty`/`period` hold their last values.
  - Constant high or constant low is distinguished via `level`.
- `rise` in the same cycle as `per_cnt` = all-ones: the capture wins, `period` = 2^CNT_W−1, no timeout.
- `hi_cnt` cannot exceed `per_cnt`, so no separate saturation is needed.
- Reset asserted mid-measurement: every register clears at once and the state returns to IDLE. The first rise after release only starts a measurement.

## Timing
- `pwm_in` first sampled high at edge N → `level` high after edge N+SYNC_STAGES−1 → `valid` high for the cycle after edge N+SYNC_STAGES.
- `duty`/`period` change on the same edge that raises `valid` and are stable until the next `valid`.
- Throughput: one result per PWM period; no back-pressure.
- With the filter enabled, every latency above increases by 2 cycles.

## Configuration
- `DPWM_CAP_GLITCH_FILTER_EN` defined:
  - a filter stage sits between the synchronizer and the delay flop;
  - the filtered level changes only after 3 consecutive equal synchronized samples;
  - pulses or gaps shorter than 3 cycles are ignored.
- Not defined: the synchronizer output feeds the delay flop directly, and single-cycle pulses are measured.

## Structure
- `dpwm_pkg` holds:
  - the state enum (IDLE, MEASURE);
  - the default `CNT_W`;
  - the all-ones limit expression.
- Sub-module `dpwm_sync_edge` contains the synchronizer, the optional glitch filter, the delay flop and the `rise` output.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- CNT_W=8, filter off, input 3 high / 5 low repeating → first rise gives no `valid`; thereafter `valid` every 8 cycles with `duty`=3, `period`=8.
- Switch to 6 high / 2 low mid-run → the next report still reads 3/8; the following one reads 6/8, with no missing `valid`.
- Hold `pwm_in` low after a period → `timeout`=1 exactly 255 cycles after the last rise, `level`=0, `duty`/`period` held. The next two rises clear `timeout` on the second one, with a fresh `valid`.
- Pull `rst` low for 2 cycles mid-period → all outputs 0, state IDLE. The first rise after release gives no `valid`; the second rise gives a correct report.
- Square wave 1 high / 1 low → `duty`=1, `period`=2 every 2 cycles.
- Filter on: inject a 1-cycle high glitch inside the low phase of the 3/8 waveform → reports stay 3/8. Filter off: same stimulus → an extra `valid` with `duty`=1.
